// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle MIPS datapath: divider states,
// iteration count and the exception vector the control unit uses on divide-by-zero.
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FINISH
   } div_state_t;

   localparam int DIV_STEPS = 32;

   localparam logic [31:0] EXC_DIV_ZERO_VEC = 32'h000000FF;

endpackage

// File: rtl/div_unit_if.sv
// Handshake and result bus between the control unit / datapath (master) and
// the sequential divider (slave).
interface div_unit_if #(
   parameter int WIDTH = 32
);

   logic             divControl;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             divBusy;
   logic             divDone;
   logic             divZero;

   modport master (
      output divControl, a, b,
      input  hi, lo, divBusy, divDone, divZero
   );

   modport slave (
      input  divControl, a, b,
      output hi, lo, divBusy, divDone, divZero
   );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift {rem, quo}
// left by one, then subtract the divisor when it fits and set the new quotient bit.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] remNext,
   output logic [WIDTH-1:0] quoNext
);

   logic [WIDTH:0] trial;

   // The extra top bit keeps the compare exact even when the shifted
   // remainder exceeds WIDTH bits.
   always_comb begin
      trial = {rem, quo[WIDTH-1]};
      if (trial >= {1'b0, divisor}) begin
         remNext = WIDTH'(trial - {1'b0, divisor});
         quoNext = {quo[WIDTH-2:0], 1'b1};
      end else begin
         remNext = trial[WIDTH-1:0];
         quoNext = {quo[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div_unit.sv
// Sequential signed divider: latches operand magnitudes, runs DIV_STEPS restoring
// iterations, then applies signs and writes HI (remainder) / LO (quotient).
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic       clk,
   input  logic       reset,
   div_unit_if.slave  bus
);

   import cpu_pkg::*;

   localparam int CW = $clog2(DIV_STEPS);
   localparam logic [CW-1:0] LAST_STEP = CW'(DIV_STEPS - 1);

   div_state_t       state;
   div_state_t       nextState;
   logic [WIDTH-1:0] remReg;
   logic [WIDTH-1:0] quoReg;
   logic [WIDTH-1:0] divisorReg;
   logic [WIDTH-1:0] remNext;
   logic [WIDTH-1:0] quoNext;
   logic [WIDTH-1:0] aMag;
   logic [WIDTH-1:0] bMag;
   logic [WIDTH-1:0] hiReg;
   logic [WIDTH-1:0] loReg;
   logic [CW-1:0]    count;
   logic             remSign;
   logic             quoSign;
   logic             zeroFlag;
   logic             doneReg;
   logic             zeroReg;
   logic             busy;

   // Magnitudes wrap in unsigned arithmetic, so |0x80000000| stays 0x80000000.
   assign aMag = bus.a[WIDTH-1] ? -bus.a : bus.a;
   assign bMag = bus.b[WIDTH-1] ? -bus.b : bus.b;

   div_step #(.WIDTH(WIDTH)) stepUnit (
      .rem     (remReg),
      .quo     (quoReg),
      .divisor (divisorReg),
      .remNext (remNext),
      .quoNext (quoNext)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= nextState;
   end

   always_comb begin
      nextState = state;
      unique case (state)
         IDLE: begin
            if (bus.divControl) nextState = (bus.b == '0) ? FINISH : CALC;
         end
         CALC: begin
            if (count == LAST_STEP) nextState = FINISH;
         end
         FINISH:  nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
   end

   // A divide-by-zero skips CALC and leaves HI/LO untouched in FINISH.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         remReg     <= '0;
         quoReg     <= '0;
         divisorReg <= '0;
         count      <= '0;
         remSign    <= 1'b0;
         quoSign    <= 1'b0;
         zeroFlag   <= 1'b0;
         hiReg      <= '0;
         loReg      <= '0;
         doneReg    <= 1'b0;
         zeroReg    <= 1'b0;
      end else begin
         doneReg <= (state == FINISH);
         zeroReg <= (state == FINISH) && zeroFlag;
         unique case (state)
            IDLE: begin
               if (bus.divControl) begin
                  remReg     <= '0;
                  quoReg     <= aMag;
                  divisorReg <= bMag;
                  count      <= '0;
                  remSign    <= bus.a[WIDTH-1];
                  quoSign    <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                  zeroFlag   <= (bus.b == '0);
               end
            end
            CALC: begin
               remReg <= remNext;
               quoReg <= quoNext;
               count  <= count + 1'b1;
            end
            FINISH: begin
               if (!zeroFlag) begin
                  loReg <= quoSign ? -quoReg : quoReg;
                  hiReg <= remSign ? -remReg : remReg;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.hi      = hiReg;
   assign bus.lo      = loReg;
   assign bus.divBusy = busy;
   assign bus.divDone = doneReg;
   assign bus.divZero = zeroReg;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: table of signed divisions with hand-computed
// results, plus sequences for divide-by-zero, ignored requests and mid-op reset.
module tb_div_unit;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] expLo;
      logic [31:0] expHi;
   } vector_t;

   logic clk;
   logic reset;
   int   compared;
   int   mismatched;

   div_unit_if #(.WIDTH(32)) bus ();

   div_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Starts an operation at edge E0 and reports the edge index of divDone
   // (0 if it never came within the budget) and divBusy midway through.
   task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv,
                                output int doneEdge, output logic busyMid);
      @(negedge clk);
      bus.a = av;
      bus.b = bv;
      bus.divControl = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.divControl = 1'b0;
      doneEdge = 0;
      busyMid = 1'b0;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk);
         #1;
         if (e == 16) busyMid = bus.divBusy;
         if (bus.divDone) begin
            doneEdge = e;
            break;
         end
      end
   endtask

   vector_t vecs[10];
   int      doneEdge;
   logic    busyMid;
   logic    sawDone;

   initial begin
      compared = 0;
      mismatched = 0;
      reset = 1'b0;
      bus.divControl = 1'b0;
      bus.a = '0;
      bus.b = '0;

      vecs[0] = '{32'd7,         32'd2,         32'd3,         32'd1};
      vecs[1] = '{32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF};
      vecs[2] = '{32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1};
      vecs[3] = '{32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0};
      vecs[4] = '{32'd100,       32'd7,         32'd14,        32'd2};
      vecs[5] = '{32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE};
      vecs[6] = '{32'd0,         32'd5,         32'd0,         32'd0};
      vecs[7] = '{32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0};
      vecs[8] = '{32'h7FFFFFFF,  32'h80000000,  32'd0,         32'h7FFFFFFF};
      vecs[9] = '{32'h80000000,  32'h80000000,  32'd1,         32'd0};

      repeat (2) @(negedge clk);
      checkOutput("resetHi",   bus.hi, 32'd0);
      checkOutput("resetLo",   bus.lo, 32'd0);
      checkOutput("resetBusy", 32'(bus.divBusy), 32'd0);
      checkOutput("resetDone", 32'(bus.divDone), 32'd0);
      checkOutput("resetZero", 32'(bus.divZero), 32'd0);
      reset = 1'b1;

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].a, vecs[i].b, doneEdge, busyMid);
         checkOutput($sformatf("v%0d.doneEdge", i), 32'(doneEdge), 32'd33);
         checkOutput($sformatf("v%0d.lo", i), bus.lo, vecs[i].expLo);
         checkOutput($sformatf("v%0d.hi", i), bus.hi, vecs[i].expHi);
         checkOutput($sformatf("v%0d.zero", i), 32'(bus.divZero), 32'd0);
         checkOutput($sformatf("v%0d.busyMid", i), 32'(busyMid), 32'd1);
         checkOutput($sformatf("v%0d.busyAfter", i), 32'(bus.divBusy), 32'd0);
         @(posedge clk);
         #1;
         checkOutput($sformatf("v%0d.donePulse", i), 32'(bus.divDone), 32'd0);
      end

      // Divide by zero must leave the previous HI/LO in place.
      applyStimulus(32'd95, 32'd10, doneEdge, busyMid);
      checkOutput("preZero.lo", bus.lo, 32'd9);
      checkOutput("preZero.hi", bus.hi, 32'd5);
      applyStimulus(32'd123, 32'd0, doneEdge, busyMid);
      checkOutput("zero.doneEdge", 32'(doneEdge), 32'd1);
      checkOutput("zero.flag", 32'(bus.divZero), 32'd1);
      checkOutput("zero.lo", bus.lo, 32'd9);
      checkOutput("zero.hi", bus.hi, 32'd5);
      @(posedge clk);
      #1;
      checkOutput("zero.flagPulse", 32'(bus.divZero), 32'd0);
      checkOutput("zero.donePulse", 32'(bus.divDone), 32'd0);

      // Second request at E5 while busy is ignored.
      @(negedge clk);
      bus.a = 32'd100;
      bus.b = 32'd7;
      bus.divControl = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.divControl = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      bus.a = 32'd1;
      bus.b = 32'd1;
      bus.divControl = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.divControl = 1'b0;
      doneEdge = 0;
      for (int e = 6; e <= 40; e++) begin
         @(posedge clk);
         #1;
         if (bus.divDone) begin
            doneEdge = e;
            break;
         end
      end
      checkOutput("ignore.doneEdge", 32'(doneEdge), 32'd33);
      checkOutput("ignore.lo", bus.lo, 32'd14);
      checkOutput("ignore.hi", bus.hi, 32'd2);

      // Reset at E10 aborts the operation with no completion pulse.
      @(negedge clk);
      bus.a = 32'd100;
      bus.b = 32'd7;
      bus.divControl = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.divControl = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("abort.busy", 32'(bus.divBusy), 32'd0);
      checkOutput("abort.hi", bus.hi, 32'd0);
      checkOutput("abort.lo", bus.lo, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      sawDone = 1'b0;
      for (int e = 0; e < 40; e++) begin
         @(posedge clk);
         #1;
         if (bus.divDone) sawDone = 1'b1;
      end
      checkOutput("abort.noDone", 32'(sawDone), 32'd0);
      applyStimulus(32'd7, 32'd2, doneEdge, busyMid);
      checkOutput("afterAbort.doneEdge", 32'(doneEdge), 32'd33);
      checkOutput("afterAbort.lo", bus.lo, 32'd3);
      checkOutput("afterAbort.hi", bus.hi, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/div_unit.md
# div_unit

Sequential signed 32-bit divider for the multicycle MIPS datapath. It answers the control unit's `divControl` request and computes quotient and remainder with a 32-iteration restoring algorithm. It drives the datapath's `div` result path into the HI/LO registers. It also raises the divide-by-zero condition, which the control unit maps to exception vector 0xFF through the exception-address mux.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width; only 32 is supported.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `divControl`  in  1  start request; sampled only in IDLE.
- `a`  in  32  dividend, two's complement (register A).
- `b`  in  32  divisor, two's complement (register B).
- `hi`  out  32  remainder; reset 0.
- `lo`  out  32  quotient; reset 0.
- `divBusy`  out  1  high while an operation is in flight; reset 0.
- `divDone`  out  1  one-cycle completion pulse; reset 0.
- `divZero`  out  1  one-cycle pulse coincident with `divDone` when the divisor was 0; reset 0.

## Operation
- States: IDLE, CALC, FINISH.
- IDLE:
  - On `divControl`=1, latch |a|, |b|, sign(a), sign(a)^sign(b).
  - Clear the remainder accumulator and set count=0.
  - If b==0, go to FINISH with the zero flag set. Otherwise go to CALC.
- CALC: each cycle performs one restoring step.
  - {rem, quo} shifts left 1.
  - If rem ≥ |b|, then rem −= |b| and quo[0]=1.
  - Increment count; after the 32nd step, go to FINISH.
- FINISH:
  - Normal case: lo = quotient sign ? −quo : quo, and hi = sign(a) ? −rem : rem.
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - Pulse `divDone`, and `divZero` if flagged, then return to IDLE.
  - Zero-divisor case: hi/lo are NOT written and keep their previous values.
- Width rules:
  - Magnitudes use 32-bit unsigned arithmetic; |0x80000000| = 0x80000000.
  - 0x80000000 / −1 gives lo=0x80000000, hi=0 (wraps, no flag).
- `divBusy` = (state != IDLE). `divControl` while busy is ignored; no queuing.
- hi/lo change only in FINISH and hold otherwise.
- Reset mid-operation: immediate return to IDLE, all outputs 0, no `divDone`.

## Timing
- Let edge E0 be the edge at which `divControl`=1 is sampled in IDLE.
- Normal division:
  - Steps occur at edges E1..E32.
  - hi/lo are updated at E33, and `divDone` is high for the cycle between E33 and E34.
  - `divBusy` is high from after E0 through E33 and low after E33.
- Divide by zero:
  - FINISH occurs at E1, so `divDone`=`divZero`=1 for the cycle between E1 and E2.
- A new request is accepted at the first edge where state is IDLE, i.e. E34 at the earliest. `divControl` held high across `divDone` therefore restarts at E34.
- Outputs are fully registered; no combinational path from inputs to outputs.

## Structure
- Shared package `cpu_pkg`:
  - state enum `div_state_t` {IDLE, CALC, FINISH}.
  - `DIV_STEPS`=32.
  - `EXC_DIV_ZERO_VEC`=32'h000000FF, used by the control unit, not by this block.
- One sub-module, `div_step`: purely combinational, one restoring iteration. Inputs are rem, quo and divisor; outputs are the next rem and quo.
- Sign handling and the FSM stay in `div_unit`.

## Test plan
- a=7, b=2, pulse at E0 → at E33: lo=3, hi=1, `divDone` single pulse, `divZero`=0, `divBusy` low after E33.
- a=−7 (0xFFFFFFF9), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also a=7, b=−2 → lo=0xFFFFFFFD, hi=1.
- Load hi/lo=5/9 from a prior op, then a=123, b=0 → `divDone`=`divZero`=1 for one cycle after E1; hi=5, lo=9 unchanged.
- a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0, `divZero`=0.
- a=100, b=7, then pulse `divControl` again at E5 with a=1, b=1 → second request ignored; at E33 lo=14, hi=2.
- Start a=100, b=7, assert `reset`=0 at E10 for one cycle → `divBusy`=0 immediately; hi=lo=0; no `divDone` ever. A subsequent request then completes normally 33 edges after its start.
